print_uart_tx: RTL and testbench

Output-side consumer of the CPU core's print port. It accepts `print_en`/`print_data` word writes, buffers them in a small FIFO, and serializes each word onto a UART 8N1 transmit line. It sits directly downstream of the core top, between the core and the board-level TX pin. The core never stalls on print: when the buffer is full, words are dropped and the drop is flagged.

---
 rtl/print_uart_tx_pkg.sv | 25 ++
 rtl/print_fifo.sv | 64 ++++++
 rtl/print_uart_tx.sv | 159 +++++++++++++++
 tb/tb_print_uart_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/print_uart_tx_pkg.sv
// Shared types and constants for the print-port UART transmitter.
// Build option: PRINT_ASCII_HEX_EN selects ASCII-hex framing (9 bytes/word)
// instead of raw little-endian bytes (4 bytes/word).
package print_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

`ifdef PRINT_ASCII_HEX_EN
  // 8 hex digits plus a trailing line feed
  localparam int UART_BYTES_PER_WORD = 9;

  // Map a nibble to its uppercase ASCII hex digit
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction
`else
  localparam int UART_BYTES_PER_WORD = 4;
`endif

endpackage

// File: rtl/print_fifo.sv
// Synchronous word FIFO buffering print writes ahead of the serializer.
// Latency: a pushed word is readable at the head from the next cycle.
// Backpressure: none internally; caller must not push when full without a pop.
module print_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     start,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^AW
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers, cleared by the asynchronous start reset
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/print_uart_tx.sv
// Print-port consumer: buffers core print words and sends them as UART 8N1 frames.
// Latency: pop to tx start bit is 1 cycle; a push into an empty FIFO pops the next cycle.
// Backpressure: none to the core; words arriving at a full FIFO are dropped, flagged sticky in overflow.
// Build option: PRINT_ASCII_HEX_EN sends each word as 8 ASCII hex digits + LF.
module print_uart_tx
  import print_uart_tx_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                   clk,
  input  logic                   start,
  input  logic                   print_en,
  input  logic [31:0]            print_data,
  output logic                   tx,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BYTE = 4'(UART_BYTES_PER_WORD - 1);

  uart_state_t   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;

  logic          push;
  logic          pop;
  logic          bit_done;
  logic [31:0]   fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    cur_byte_d;

  print_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .start     (start),
    .push      (push),
    .push_data (print_data),
    .pop       (pop),
    .rd_data   (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bit_done = (baud_q == BAUD_LAST);
  // A full FIFO still takes a word when the serializer drains one in the same cycle
  assign push     = print_en && (!fifo_full || pop);

  // Serializer next-state: IDLE pops a word, then START/DATA/STOP per byte until the word is done
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_head;
          byte_idx_d = '0;
          bit_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (byte_idx_q == LAST_BYTE) begin
            state_d = IDLE;
          end else begin
            // Next byte follows directly with no idle gap
            byte_idx_d = byte_idx_q + 4'd1;
`ifdef PRINT_ASCII_HEX_EN
            shift_d    = {shift_q[27:0], 4'h0};
`else
            shift_d    = {8'h00, shift_q[31:8]};
`endif
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) begin
      baud_d = bit_done ? '0 : baud_q + BW'(1);
    end
  end

  // Byte about to be on the line, derived from the next-cycle word/byte position
`ifdef PRINT_ASCII_HEX_EN
  assign cur_byte_d = (byte_idx_d == 4'd8) ? 8'h0A : nibble_to_ascii(shift_d[31:28]);
`else
  assign cur_byte_d = shift_d[7:0];
`endif

  // Registered outputs: line level, activity and sticky drop flag
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte_d[bit_cnt_d];
      default: tx_d = 1'b1;
    endcase
    busy_d     = (state_d != IDLE) || push || (fifo_count > CW'(pop));
    overflow_d = overflow_q || (print_en && !push);
  end

  // State registers; start low forces an idle-high line and discards the word in flight
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_print_uart_tx.sv
module tb_print_uart_tx;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
`ifdef PRINT_ASCII_HEX_EN
  localparam int BPW   = 9;
`else
  localparam int BPW   = 4;
`endif
  localparam int WORD_CYC = BPW * 10 * CPB;

  logic        clk = 1'b0;
  logic        start = 1'b0;
  logic        print_en = 1'b0;
  logic [31:0] print_data = '0;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifo_count;

  print_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .start      (start),
    .print_en   (print_en),
    .print_data (print_data),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue occupancy, time the transmitter frees up, sticky drop flag
  int         m_sz = 0;
  int         m_free_at = 0;
  bit         m_ovf = 1'b0;
  logic [7:0] sb[$];
  int         epoch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
`ifdef PRINT_ASCII_HEX_EN
    logic [3:0] nib;
    if (i == 8) return 8'h0A;
    nib = w[28 - 4*i +: 4];
    return (nib < 10) ? (8'd48 + 8'(nib)) : (8'd55 + 8'(nib));
`else
    return w[8*i +: 8];
`endif
  endfunction

  // Transmitter is mid-word after edge e
  function automatic bit m_active(input int e);
    return e < m_free_at - 1;
  endfunction

  function automatic void model_step(input int e, input bit en, input logic [31:0] d);
    if (m_sz > 0 && e >= m_free_at) begin
      m_sz--;
      m_free_at = e + WORD_CYC + 1;
    end
    if (en) begin
      if (m_sz < DEPTH) begin
        m_sz++;
        for (int i = 0; i < BPW; i++) sb.push_back(exp_byte(d, i));
      end else begin
        m_ovf = 1'b1;
      end
    end
  endfunction

  // One clock: drive at negedge, model the coming edge, check at next negedge
  task automatic cyc(input bit en, input logic [31:0] d);
    print_en   = en;
    print_data = d;
    model_step(edge_cnt + 1, en, d);
    @(negedge clk);
    print_en = 1'b0;
    check("fifo_count", 32'(fifo_count), 32'(m_sz));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("busy", 32'(busy), 32'((m_sz > 0) || m_active(edge_cnt)));
    if (!m_active(edge_cnt)) check("tx_idle", 32'(tx), 32'd1);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge
  task automatic do_reset();
    #1 start = 1'b0;
    epoch++;
    m_sz = 0;
    m_free_at = 0;
    m_ovf = 1'b0;
    sb.delete();
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || m_sz > 0 || m_active(edge_cnt)) && k < DEPTH * (WORD_CYC + 2) + 200) begin
      cyc(1'b0, '0);
      k++;
    end
    repeat (4) cyc(1'b0, '0);
    check("drain_scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: UART receiver sampling mid-bit, compares each byte with the scoreboard
  initial begin : monitor
    logic [7:0] mb;
    logic       mstop;
    logic       mprev;
    int         mep;
    mprev = 1'b1;
    forever begin
      @(negedge clk);
      if (start && mprev && tx === 1'b0) begin
        mep = epoch;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mb[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        mstop = tx;
        if (mep == epoch) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_unexpected_byte: got %0h expected none", mb);
          end else begin
            check("tx_byte", 32'(mb), 32'(sb.pop_front()));
            check("tx_stop_bit", 32'(mstop), 32'd1);
          end
        end
      end
      mprev = tx;
    end
  end

  initial begin : watchdog
    #(1_000_000);
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int pe;
    int k;
    @(negedge clk);
    do_reset();

    // Idle line after reset
    for (int i = 0; i < 1000; i++) cyc(1'b0, '0);

    // Single word: start-bit latency and busy duration
    cyc(1'b1, 32'h4F4B0A21);
    pe = edge_cnt;
    check("tx_high_at_push", 32'(tx), 32'd1);
    k = 0;
    while (tx !== 1'b0 && k < 20) begin cyc(1'b0, '0); k++; end
    check("tx_low_delay", 32'(edge_cnt - pe), 32'd1);
    k = 0;
    while (busy === 1'b1 && k < WORD_CYC + 50) begin cyc(1'b0, '0); k++; end
    check("busy_fall_delay", 32'(edge_cnt - pe), 32'(WORD_CYC + 1));
    drain();

    // Six back-to-back writes into a 4-deep FIFO: sixth dropped
    do_reset();
    for (int w = 1; w <= 6; w++) cyc(1'b1, 32'(w));
    check("ovf_after_drop", 32'(overflow), 32'd1);
    check("count_full", 32'(fifo_count), 32'd4);
    drain();
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with push coincident with pop: accepted, no overflow
    do_reset();
    for (int w = 1; w <= 5; w++) cyc(1'b1, 32'h100 + 32'(w));
    check("count_full_before", 32'(fifo_count), 32'd4);
    k = 0;
    while (edge_cnt + 1 != m_free_at && k < WORD_CYC + 50) begin cyc(1'b0, '0); k++; end
    cyc(1'b1, 32'h1FF);
    check("push_pop_full_count", 32'(fifo_count), 32'd4);
    check("push_pop_full_ovf", 32'(overflow), 32'd0);
    drain();

    // Reset during the second byte's data bits with three words queued
    do_reset();
    cyc(1'b1, 32'hA1B2C3D4);
    cyc(1'b1, 32'h11111111);
    cyc(1'b1, 32'h22222222);
    cyc(1'b1, 32'h33333333);
    check("queued_three", 32'(fifo_count), 32'd3);
    repeat (10 * CPB + CPB + 2) cyc(1'b0, '0);
    do_reset();
    repeat (60) cyc(1'b0, '0);
    cyc(1'b1, 32'h5A3C96E1);
    drain();

    // Randomized traffic with occasional bursts to provoke drops
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        for (int j = 0; j < 6; j++) cyc(1'b1, $urandom);
      end else begin
        cyc($urandom_range(0, 39) == 0, $urandom);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
